fir_mac_core: RTL



---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_mac_unit.sv | 30 +++
 rtl/fir_mac_core.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the sequential FIR datapath.
// Helpers work on a fixed MAX_W-bit signed carrier; callers cast to and from their own widths.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  localparam int MAX_W = 128;

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  function automatic logic signed [MAX_W-1:0] out_max(input int out_w);
    logic signed [MAX_W-1:0] m;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < out_w - 1);
    return m;
  endfunction

  // The most negative OUT_W value is the bitwise complement of the most positive one.
  function automatic logic sat_hit(input logic signed [MAX_W-1:0] v, input int out_w);
    return (v > out_max(out_w)) || (v < ~out_max(out_w));
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] v,
                                                        input int out_w,
                                                        input logic sat_en);
    if (sat_en && (v > out_max(out_w))) return out_max(out_w);
    if (sat_en && (v < ~out_max(out_w))) return ~out_max(out_w);
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiplier feeding an accumulator register with synchronous clear and enable.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;

  assign prod = PROD_W'(x) * PROD_W'(c);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/fir_mac_core.sv
// Sequential single-multiplier FIR: one MAC per cycle, result on a valid/ready stream.
// Build macro FIR_SATURATE_EN: clamp output to OUT_W and raise a sticky sat_flag.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | accumulating x[idx]*c[idx]; one settle cycle once the last tap is in
// OUT   | result presented and held until m_ready
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int NTAPS  = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       coef_we,
  output logic                       coef_ready,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [DATA_W-1:0]   s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [OUT_W-1:0]    m_data,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);

`ifdef FIR_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  fir_state_e state, state_n;

  logic signed [DATA_W-1:0] x_dl [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic [AW-1:0]            idx;
  logic                     acc_done;
  logic                     accept;
  logic                     mac_en;
  logic                     out_load;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [OUT_W-1:0]  out_val;

  assign s_ready    = (state == IDLE);
  assign coef_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = s_valid && s_ready;
  assign mac_en     = (state == MAC) && !acc_done;
  assign out_load   = (state == MAC) && acc_done;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)   state_n = MAC;
      MAC:     if (acc_done) state_n = OUT;
      OUT:     if (m_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Coefficient RAM and delay line; a write coinciding with an accept lands before MAC reads it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_dl[k] <= '0;
        coef[k] <= '0;
      end
    end else begin
      if (coef_we && coef_ready) coef[coef_addr] <= coef_wdata;
      if (accept) begin
        x_dl[0] <= s_data;
        for (int k = 1; k < NTAPS; k++) x_dl[k] <= x_dl[k-1];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx      <= '0;
      acc_done <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      acc_done <= 1'b0;
    end else if (mac_en) begin
      idx <= idx + AW'(1);
      if (idx == AW'(NTAPS - 1)) acc_done <= 1'b1;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (accept),
    .en      (mac_en),
    .x       (x_dl[idx]),
    .c       (coef[idx]),
    .acc     (acc)
  );

  assign acc_sh  = acc >>> SHIFT;
  assign out_val = OUT_W'(sat_trunc(MAX_W'(acc_sh), OUT_W, SAT_EN));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (out_load) begin
      m_valid <= 1'b1;
      m_data  <= out_val;
    end else if ((state == OUT) && m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef FIR_SATURATE_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                                          sat_flag <= 1'b0;
    else if (out_load && sat_hit(MAX_W'(acc_sh), OUT_W))   sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
